// File: rtl/hash_misr_multi.sv
// hash_misr_multi: N_CHANNELS independent MISR signatures with beat counters,
// per-channel clear and a registered read-back port. With WIDTH=32 and the
// default POLY/INITIAL_VALUE each channel matches the legacy 32-bit hash.
module hash_misr_multi #(
    parameter int          WIDTH         = 32,
    parameter int          N_CHANNELS    = 4,
    parameter logic [31:0] POLY          = 32'h00000057,
    parameter logic [31:0] INITIAL_VALUE = 32'h000014D6,
    parameter int          CNT_WIDTH     = 16,
    parameter int          CHAN_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [CHAN_W-1:0]    in_chan,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clr_valid,
    input  logic [CHAN_W-1:0]    clr_chan,
    input  logic                 rd_req,
    input  logic [CHAN_W-1:0]    rd_chan,
    output logic                 rd_valid,
    output logic [WIDTH-1:0]     rd_value,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 err_chan
);

    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INITIAL_VALUE);
    // The top bit always takes value[0], so only the low WIDTH-1 taps matter.
    localparam logic [WIDTH-2:0] TAPS   = (WIDTH-1)'(POLY);

    logic [WIDTH-1:0]     sig [N_CHANNELS];
    logic [CNT_WIDTH-1:0] cnt [N_CHANNELS];

    logic                 in_ok;
    logic                 clr_ok;
    logic                 rd_ok;
    logic [WIDTH-1:0]     rd_sig;
    logic [CNT_WIDTH-1:0] rd_cnt;

    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] v,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] n;
        n[WIDTH-1]   = d[WIDTH-1] ^ v[0];
        n[WIDTH-2:0] = d[WIDTH-2:0] ^ v[WIDTH-1:1] ^ (TAPS & {(WIDTH-1){v[0]}});
        return n;
    endfunction

    function automatic logic chan_in_range(input logic [CHAN_W-1:0] c);
        return 32'(c) < 32'(N_CHANNELS);
    endfunction

    // Range checks for the three channel-addressed ports.
    always_comb begin
        in_ok  = chan_in_range(in_chan);
        clr_ok = chan_in_range(clr_chan);
        rd_ok  = chan_in_range(rd_chan);
    end

    // Read mux; an out-of-range index matches no channel and returns zeros.
    always_comb begin
        rd_sig = '0;
        rd_cnt = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (rd_chan == CHAN_W'(i)) begin
                rd_sig = sig[i];
                rd_cnt = cnt[i];
            end
        end
    end

    // Per-channel signature and beat counter; clear beats update on the same channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                sig[i] <= INIT_W;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (clr_valid && clr_ok && clr_chan == CHAN_W'(i)) begin
                    sig[i] <= INIT_W;
                    cnt[i] <= '0;
                end else if (in_valid && in_ok && in_chan == CHAN_W'(i)) begin
                    sig[i] <= misr_next(sig[i], in_data);
                    if (cnt[i] != '1)
                        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // One-stage read register; samples pre-update state, holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_value <= '0;
            rd_count <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_value <= rd_sig;
                rd_count <= rd_cnt;
            end
        end
    end

    // Sticky flag for any out-of-range channel index presented on any port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_chan <= 1'b0;
        else if ((in_valid && !in_ok) || (clr_valid && !clr_ok) || (rd_req && !rd_ok))
            err_chan <= 1'b1;
    end

endmodule

// File: tb/tb_hash_misr_multi.sv
// Bench for hash_misr_multi: two instances (default, and 3 channels with a
// 4-bit counter) share one stimulus stream and are checked against a
// behavioural signature model every cycle.
module tb_hash_misr_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_chan;
    logic [31:0] in_data;
    logic        clr_valid;
    logic [1:0]  clr_chan;
    logic        rd_req;
    logic [1:0]  rd_chan;

    logic        a_rd_valid, b_rd_valid;
    logic [31:0] a_rd_value, b_rd_value;
    logic [15:0] a_rd_count;
    logic [3:0]  b_rd_count;
    logic        a_err, b_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hash_misr_multi dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
        .clr_valid(clr_valid), .clr_chan(clr_chan),
        .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_valid(a_rd_valid), .rd_value(a_rd_value), .rd_count(a_rd_count),
        .err_chan(a_err)
    );

    hash_misr_multi #(.N_CHANNELS(3), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
        .clr_valid(clr_valid), .clr_chan(clr_chan),
        .rd_req(rd_req), .rd_chan(rd_chan),
        .rd_valid(b_rd_valid), .rd_value(b_rd_value), .rd_count(b_rd_count),
        .err_chan(b_err)
    );

    // Reference model: index 0 = dut_a (4 ch, 16-bit count), 1 = dut_b (3 ch, 4-bit count)
    logic [31:0] m_sig  [2][4];
    int          m_cnt  [2][4];
    bit          m_rv   [2];
    logic [31:0] m_rval [2];
    int          m_rcnt [2];
    bit          m_err  [2];

    function automatic int nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic int cmax(input int m);
        return (m == 0) ? 65535 : 15;
    endfunction

    // Signature step as a rotate-right plus conditional polynomial XOR.
    function automatic logic [31:0] ref_next(input logic [31:0] v, input logic [31:0] d);
        logic [31:0] r;
        r = (v >> 1) | (v << 31);
        if (v[0])
            r = r ^ (32'h00000057 & 32'h7FFFFFFF);
        return r ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                m_sig[m][c] = 32'h000014D6;
                m_cnt[m][c] = 0;
            end
            m_rv[m]   = 1'b0;
            m_rval[m] = '0;
            m_rcnt[m] = 0;
            m_err[m]  = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".a_rdv"}, 32'(a_rd_valid), 32'(m_rv[0]));
        chk({tag, ".a_val"}, a_rd_value, m_rval[0]);
        chk({tag, ".a_cnt"}, 32'(a_rd_count), 32'(m_rcnt[0]));
        chk({tag, ".a_err"}, 32'(a_err), 32'(m_err[0]));
        chk({tag, ".b_rdv"}, 32'(b_rd_valid), 32'(m_rv[1]));
        chk({tag, ".b_val"}, b_rd_value, m_rval[1]);
        chk({tag, ".b_cnt"}, 32'(b_rd_count), 32'(m_rcnt[1]));
        chk({tag, ".b_err"}, 32'(b_err), 32'(m_err[1]));
    endtask

    // One clock: drive inputs, advance the model from pre-edge state, check after the edge.
    task automatic cyc(input string tag, input bit iv, input int ic, input logic [31:0] id,
                       input bit cv, input int cc, input bit rv, input int rc);
        in_valid  = iv;
        in_chan   = 2'(ic);
        in_data   = id;
        clr_valid = cv;
        clr_chan  = 2'(cc);
        rd_req    = rv;
        rd_chan   = 2'(rc);
        for (int m = 0; m < 2; m++) begin
            m_rv[m] = rv;
            if (rv) begin
                m_rval[m] = (rc < nch(m)) ? m_sig[m][rc] : 32'h0;
                m_rcnt[m] = (rc < nch(m)) ? m_cnt[m][rc] : 0;
            end
            if ((iv && ic >= nch(m)) || (cv && cc >= nch(m)) || (rv && rc >= nch(m)))
                m_err[m] = 1'b1;
            if (iv && ic < nch(m) && !(cv && cc == ic)) begin
                m_sig[m][ic] = ref_next(m_sig[m][ic], id);
                if (m_cnt[m][ic] < cmax(m))
                    m_cnt[m][ic]++;
            end
            if (cv && cc < nch(m)) begin
                m_sig[m][cc] = 32'h000014D6;
                m_cnt[m][cc] = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    // Assert reset between edges with traffic pending; outputs must clear without a clock.
    task automatic mid_reset(input string tag);
        in_valid = 1'b1;
        in_chan  = 2'd1;
        rd_req   = 1'b1;
        rd_chan  = 2'd0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rd_req   = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        in_valid = 0; in_chan = 0; in_data = 0;
        clr_valid = 0; clr_chan = 0; rd_req = 0; rd_chan = 0;
        reset = 1'b1;
        model_reset();
        #3;
        check_outputs("rst");
        #20;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two zero beats on ch0, reading after each.
        cyc("b1", 1, 0, 32'h0, 0, 0, 0, 0);
        cyc("r1", 0, 0, 32'h0, 0, 0, 1, 0);
        chk("beat1_val", a_rd_value, 32'h00000A6B);
        chk("beat1_cnt", 32'(a_rd_count), 32'd1);
        cyc("b2", 1, 0, 32'h0, 0, 0, 0, 0);
        cyc("r2", 0, 0, 32'h0, 1, 3, 1, 0);
        chk("beat2_val", a_rd_value, 32'h80000562);
        chk("beat2_cnt", 32'(a_rd_count), 32'd2);

        // Fresh start: all-ones into ch1, then read ch1 and ch0 back to back.
        mid_reset("rst2");
        cyc("u1", 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
        cyc("r_c1", 0, 0, 32'h0, 0, 0, 1, 1);
        chk("ch1_val", a_rd_value, 32'hFFFFF594);
        chk("ch1_cnt", 32'(a_rd_count), 32'd1);
        cyc("r_c0", 0, 0, 32'h0, 0, 0, 1, 0);
        chk("ch0_val", a_rd_value, 32'h000014D6);
        chk("ch0_cnt", 32'(a_rd_count), 32'd0);
        idle("hold");

        // Clear and update ch2 together after three beats: clear wins.
        for (int k = 0; k < 3; k++)
            cyc("u2", 1, 2, $urandom, 0, 0, 0, 0);
        cyc("clr_upd", 1, 2, $urandom, 1, 2, 0, 0);
        cyc("r_c2", 0, 0, 32'h0, 0, 0, 1, 2);
        chk("clr_val", a_rd_value, 32'h000014D6);
        chk("clr_cnt", 32'(a_rd_count), 32'd0);

        // Update and read ch0 in the same cycle: pre-update value, then new value.
        cyc("upd_rd", 1, 0, 32'h12345678, 0, 0, 1, 0);
        chk("pre_val", a_rd_value, 32'h000014D6);
        cyc("post_rd", 0, 0, 32'h0, 0, 0, 1, 0);
        chk("post_val", a_rd_value, 32'h12345678 ^ 32'h00000A6B);

        // Saturation on dut_b (4-bit count) with 17 beats to ch2.
        for (int k = 0; k < 17; k++)
            cyc("sat", 1, 2, $urandom, 0, 0, 0, 0);
        cyc("sat_rd", 0, 0, 32'h0, 0, 0, 1, 2);
        chk("sat_cnt", 32'(b_rd_count), 32'd15);
        cyc("sat_more", 1, 2, 32'hA5A5A5A5, 0, 0, 1, 2);
        cyc("sat_rd2", 0, 0, 32'h0, 0, 0, 1, 2);
        chk("sat_cnt2", 32'(b_rd_count), 32'd15);

        // Channel 3 is out of range on dut_b only.
        cyc("bad_ch", 1, 3, $urandom, 0, 0, 0, 0);
        chk("err_b", 32'(b_err), 32'd1);
        chk("err_a", 32'(a_err), 32'd0);
        cyc("bad_rd", 0, 0, 32'h0, 0, 0, 1, 3);
        idle("err_hold");
        mid_reset("rst3");
        idle("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cyc("rnd",
                ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                ($urandom_range(0, 1) != 0), $urandom_range(0, 3));
            if (n == 300)
                mid_reset("rst_rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
